// File: rtl/load_unit_if.sv
// ---------------------------------------------------------------------------
// load_unit_if : native valid/ready read bus between the load unit and memory.
//   mem_valid  load unit -> memory  read request, held for the whole request
//   mem_addr   load unit -> memory  word-aligned read address
//   mem_ready  memory -> load unit  response strobe, qualifies mem_rdata
//   mem_rdata  memory -> load unit  read word
// The master modport is the load unit; the slave modport is the memory side.
// ---------------------------------------------------------------------------
interface load_unit_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, output mem_addr,
                  input  mem_ready, input  mem_rdata);
  modport slave  (input  mem_valid, input  mem_addr,
                  output mem_ready, output mem_rdata);
endinterface

// File: rtl/load_unit.sv
// ---------------------------------------------------------------------------
// load_unit : multicycle load path of the rv32im core.
// Accepts one load (byte address + funct3), issues a word-aligned read on the
// memory bus, extracts and extends the addressed byte/halfword/word and returns
// it with a one-cycle done pulse. Misaligned, illegal and timed-out accesses
// complete with error=1 and a cause code instead of data.
//   clk, resetn          core clock, asynchronous active-low reset
//   start, funct3, addr  load request (sampled only while idle)
//   busy                 high in every state except IDLE
//   done                 one-cycle completion pulse
//   result, error, cause completion data/status, held until the next accepted start
//   mem                  memory read bus (master side)
// ---------------------------------------------------------------------------
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        error,
  output logic [1:0]  cause,
  load_unit_if.master mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  localparam logic [1:0] C_NONE     = 2'd0;
  localparam logic [1:0] C_MISALIGN = 2'd1;
  localparam logic [1:0] C_ILLEGAL  = 2'd2;
  localparam logic [1:0] C_TIMEOUT  = 2'd3;

  logic [1:0]  r_state;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [7:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_error;
  logic [1:0]  r_cause;

  logic        w_illegal;
  logic        w_misalign;
  logic [7:0]  w_cnt_next;

  // Select the addressed lane and extend it according to the load type.
  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  off,
                                          input logic [31:0] word);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    extract = 32'(b);
      3'd1:    extract = 32'(h);
      3'd4:    extract = {24'd0, b};
      3'd5:    extract = {16'd0, h};
      default: extract = word;
    endcase
  endfunction

  always_comb begin
    w_illegal  = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    w_misalign = 1'b0;
    case (funct3)
      3'd1, 3'd5: w_misalign = addr[0];
      3'd2:       w_misalign = (addr[1:0] != 2'b00);
      default:    w_misalign = 1'b0;
    endcase
    w_cnt_next = r_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_f3     <= 3'd0;
      r_addr   <= 32'd0;
      r_cnt    <= 8'd0;
      r_result <= 32'd0;
      r_error  <= 1'b0;
      r_cause  <= C_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_illegal || w_misalign) begin
              // Rejected without touching the bus; illegal beats misaligned.
              r_state  <= S_DONE;
              r_result <= 32'd0;
              r_error  <= 1'b1;
              r_cause  <= w_illegal ? C_ILLEGAL : C_MISALIGN;
            end else begin
              r_state  <= S_REQ;
              r_f3     <= funct3;
              r_addr   <= addr;
              r_cnt    <= 8'd0;
              r_result <= 32'd0;
              r_error  <= 1'b0;
              r_cause  <= C_NONE;
            end
          end
        end
        S_REQ: begin
          // A response in the final allowed cycle still counts as success.
          if (mem.mem_ready) begin
            r_state  <= S_DONE;
            r_result <= extract(r_f3, r_addr[1:0], mem.mem_rdata);
          end else begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == LP_TIMEOUT) begin
              r_state  <= S_DONE;
              r_result <= 32'd0;
              r_error  <= 1'b1;
              r_cause  <= C_TIMEOUT;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded straight from the state register so reset drops mem_valid at once.
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign result        = r_result;
  assign error         = r_error;
  assign cause         = r_cause;
  assign mem.mem_valid = (r_state == S_REQ);
  assign mem.mem_addr  = {r_addr[31:2], 2'b00};

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        error;
  logic [1:0]  cause;

  int n_vec = 0;
  int n_err = 0;

  load_unit_if bus ();

  load_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .funct3 (funct3),
    .addr   (addr),
    .busy   (busy),
    .done   (done),
    .result (result),
    .error  (error),
    .cause  (cause),
    .mem    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Legal load: 'waits' REQ cycles without mem_ready, then the response.
  task automatic legal_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] maddr, input logic [31:0] rd,
                            input int waits, input logic [31:0] exp);
    start = 1'b1; funct3 = f3; addr = a; bus.mem_ready = 1'b0; bus.mem_rdata = rd;
    tick();
    start = 1'b0;
    check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    check({tag, ".mem_valid"}, {31'd0, bus.mem_valid}, 32'd1);
    check({tag, ".mem_addr"}, bus.mem_addr, maddr);
    check({tag, ".done_early"}, {31'd0, done}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      tick();
      check({tag, ".wait_valid"}, {31'd0, bus.mem_valid}, 32'd1);
      check({tag, ".wait_done"}, {31'd0, done}, 32'd0);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".result"}, result, exp);
    check({tag, ".error"}, {31'd0, error}, 32'd0);
    check({tag, ".cause"}, {30'd0, cause}, 32'd0);
    check({tag, ".valid_off"}, {31'd0, bus.mem_valid}, 32'd0);
    tick();
    check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, ".idle"}, {31'd0, busy}, 32'd0);
    check({tag, ".held"}, result, exp);
  endtask

  // Rejected load: done one edge after start, no bus cycle.
  task automatic bad_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [1:0] exp_cause);
    start = 1'b1; funct3 = f3; addr = a;
    tick();
    start = 1'b0;
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".error"}, {31'd0, error}, 32'd1);
    check({tag, ".cause"}, {30'd0, cause}, {30'd0, exp_cause});
    check({tag, ".result"}, result, 32'd0);
    check({tag, ".mem_valid"}, {31'd0, bus.mem_valid}, 32'd0);
    tick();
    check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, ".mem_valid2"}, {31'd0, bus.mem_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; funct3 = 3'd0; addr = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    tick();
    tick();
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.error", {31'd0, error}, 32'd0);
    check("rst.cause", {30'd0, cause}, 32'd0);
    check("rst.mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst.mem_addr", bus.mem_addr, 32'd0);
    resetn = 1'b1;
    tick();

    // Extension cases on data 0x80A1B2C3
    legal_load("lb103",  3'd0, 32'h103, 32'h100, 32'h80A1B2C3, 0, 32'hFFFFFF80);
    legal_load("lbu103", 3'd4, 32'h103, 32'h100, 32'h80A1B2C3, 0, 32'h00000080);
    legal_load("lb101",  3'd0, 32'h101, 32'h100, 32'h80A1B2C3, 0, 32'hFFFFFFB2);
    legal_load("lbu100", 3'd4, 32'h100, 32'h100, 32'h80A1B2C3, 0, 32'h000000C3);
    legal_load("lh102",  3'd1, 32'h102, 32'h100, 32'h80A1B2C3, 0, 32'hFFFF80A1);
    legal_load("lhu102", 3'd5, 32'h102, 32'h100, 32'h80A1B2C3, 0, 32'h000080A1);
    legal_load("lh100",  3'd1, 32'h100, 32'h100, 32'h80A1B2C3, 0, 32'hFFFFB2C3);
    legal_load("lw104",  3'd2, 32'h104, 32'h104, 32'h80A1B2C3, 1, 32'h80A1B2C3);

    // Rejected requests
    bad_load("mis_lw101", 3'd2, 32'h101, 2'd1);
    bad_load("mis_lh101", 3'd1, 32'h101, 2'd1);
    bad_load("ill_f3_3",  3'd3, 32'h102, 2'd2);
    bad_load("ill_f3_7",  3'd7, 32'h100, 2'd2);

    // Timeout: no response for 4 REQ cycles
    start = 1'b1; funct3 = 3'd2; addr = 32'h300; bus.mem_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("to.valid", {31'd0, bus.mem_valid}, 32'd1);
      check("to.nodone", {31'd0, done}, 32'd0);
      tick();
    end
    check("to.done", {31'd0, done}, 32'd1);
    check("to.error", {31'd0, error}, 32'd1);
    check("to.cause", {30'd0, cause}, 32'd3);
    check("to.result", result, 32'd0);
    check("to.valid_off", {31'd0, bus.mem_valid}, 32'd0);
    tick();
    check("to.idle", {31'd0, busy}, 32'd0);

    // Response on the 4th REQ cycle beats the timeout
    legal_load("to_edge", 3'd2, 32'h308, 32'h308, 32'hCAFEF00D, 3, 32'hCAFEF00D);

    // Reset in the middle of REQ
    start = 1'b1; funct3 = 3'd2; addr = 32'h200; bus.mem_ready = 1'b0;
    tick();
    start = 1'b0;
    check("rstmid.valid_before", {31'd0, bus.mem_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rstmid.valid_async", {31'd0, bus.mem_valid}, 32'd0);
    check("rstmid.busy", {31'd0, busy}, 32'd0);
    check("rstmid.done", {31'd0, done}, 32'd0);
    check("rstmid.mem_addr", bus.mem_addr, 32'd0);
    #1 resetn = 1'b1;
    tick();
    check("rstmid.nodone1", {31'd0, done}, 32'd0);
    tick();
    check("rstmid.nodone2", {31'd0, done}, 32'd0);
    legal_load("lw200", 3'd2, 32'h200, 32'h200, 32'h12345678, 0, 32'h12345678);

    // start pulses while busy are ignored
    start = 1'b1; funct3 = 3'd2; addr = 32'h400; bus.mem_ready = 1'b0; bus.mem_rdata = 32'hA5A5_0001;
    tick();
    funct3 = 3'd3; addr = 32'h104;
    tick();
    check("ign.addr", bus.mem_addr, 32'h400);
    check("ign.valid", {31'd0, bus.mem_valid}, 32'd1);
    check("ign.nodone", {31'd0, done}, 32'd0);
    funct3 = 3'd2; addr = 32'h500; bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("ign.done", {31'd0, done}, 32'd1);
    check("ign.result", result, 32'hA5A50001);
    tick();
    start = 1'b0;
    check("ign.idle_after_done", {31'd0, busy}, 32'd0);
    check("ign.addr_kept", bus.mem_addr, 32'h400);
    tick();
    check("ign.still_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
